// File: rtl/alu_operand_sequencer_if.sv
// Board-side bus of the operand sequencer: switch/button inputs, operands to the
// multiplier, its product back, and the held result/status for display.
interface alu_operand_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_data;
    logic             btn_load;
    logic             btn_clear;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic [WIDTH-1:0] result_in;
    logic [WIDTH-1:0] result_q;
    logic             result_valid;
    logic [1:0]       state_dbg;

    modport master (
        output sw_data, btn_load, btn_clear, result_in,
        input  op_a, op_b, op_valid, result_q, result_valid, state_dbg
    );

    modport slave (
        input  sw_data, btn_load, btn_clear, result_in,
        output op_a, op_b, op_valid, result_q, result_valid, state_dbg
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Captures A then B from switches on debounced load presses, presents them to the
// multiplier for one EXEC cycle, then registers and holds the product for display.
module alu_operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    alu_operand_sequencer_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_B = 2'b01,
        EXEC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [1:0]    load_sync;
    logic [1:0]    clr_sync;
    logic [CW-1:0] deb_cnt;
    logic          deb_level;
    logic          deb_prev;
    logic          load_pulse;
    logic          clr;

    // Two-stage synchronizers for both raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_sync <= '0;
            clr_sync  <= '0;
        end else begin
            load_sync <= {load_sync[0], bus.btn_load};
            clr_sync  <= {clr_sync[0], bus.btn_clear};
        end
    end

    // Counter runs only while the synced level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
        end else begin
            deb_prev <= deb_level;
            if (load_sync[1] == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_MAX) begin
                deb_cnt   <= '0;
                deb_level <= load_sync[1];
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign load_pulse = deb_level & ~deb_prev;
    assign clr        = clr_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (load_pulse) begin
                    op_a_d  = bus.sw_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (load_pulse) begin
                    op_b_d  = bus.sw_data;
                    state_d = EXEC;
                end
            end
            // Operands are already registered, so the product is settled here.
            EXEC: begin
                result_d = bus.result_in;
                state_d  = SHOW;
            end
            SHOW: begin
                if (load_pulse) begin
                    op_a_d  = bus.sw_data;
                    state_d = WAIT_B;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d  = IDLE;
            op_a_d   = '0;
            op_b_d   = '0;
            result_d = '0;
        end
    end

    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.result_q     = result_q;
    assign bus.op_valid     = (state_q == EXEC);
    assign bus.result_valid = (state_q == SHOW);
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized bench for alu_operand_sequencer against a press-level model of the
// capture sequence (A, B, show, reload) with clear and reset events.
module tb_alu_operand_sequencer;
    localparam int WIDTH = 4;
    localparam int DEB   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_operand_sequencer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // The combinational multiplier downstream of the sequencer.
    logic [7:0] prod;
    assign prod          = bus.op_a * bus.op_b;
    assign bus.result_in = prod[3:0];

    logic [14:0] obs;
    assign obs = {bus.op_a, bus.op_b, bus.result_q, bus.result_valid, bus.state_dbg};

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = nothing captured, 1 = A held awaiting B, 2 = product on show.
    logic [3:0] m_a = 0, m_b = 0, m_r = 0;
    int         m_phase = 0;

    function automatic logic [14:0] model_view();
        logic [1:0] st;
        st = (m_phase == 0) ? 2'b00 : (m_phase == 1) ? 2'b01 : 2'b11;
        return {m_a, m_b, m_r, (m_phase == 2), st};
    endfunction

    function automatic void model_press(input logic [3:0] sw);
        if (m_phase == 1) begin
            m_b     = sw;
            m_r     = 4'((int'(m_a) * int'(sw)) % 16);
            m_phase = 2;
        end else begin
            m_a     = sw;
            m_phase = 1;
        end
    endfunction

    function automatic void model_clear();
        m_a = 0; m_b = 0; m_r = 0; m_phase = 0;
    endfunction

    task automatic press(input logic [3:0] sw, input bit bouncy, output int vld);
        vld = 0;
        @(posedge clk); #1;
        bus.sw_data = sw;
        if (bouncy) begin
            for (int i = 0; i < 3; i++) begin
                bus.btn_load = 1'b1;
                repeat ($urandom_range(1, DEB - 3)) @(posedge clk);
                #1 bus.btn_load = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        bus.btn_load = 1'b1;
        repeat (DEB + 8) begin @(negedge clk); if (bus.op_valid) vld++; end
        bus.btn_load = 1'b0;
        if (bouncy) begin
            @(posedge clk); #1 bus.btn_load = 1'b1;
            repeat (2) @(posedge clk);
            #1 bus.btn_load = 1'b0;
        end
        repeat (DEB + 8) begin @(negedge clk); if (bus.op_valid) vld++; end
        bus.sw_data = 4'($urandom);
        model_press(sw);
    endtask

    task automatic clear_pulse();
        @(posedge clk); #1 bus.btn_clear = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.btn_clear = 1'b0;
        repeat (4) @(negedge clk);
        model_clear();
    endtask

    task automatic test_reset();
        bus.sw_data = 4'hA; bus.btn_load = 1'b0; bus.btn_clear = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs !== 15'd0 || bus.op_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: got %h/%b exp 0/0", obs, bus.op_valid);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (obs !== model_view()) begin
            n_fail++; $display("FAIL reset_release: got %h exp %h", obs, model_view());
        end
    endtask

    task automatic test_basic();
        int vld;
        press(4'h3, 1'b0, vld);
        n_checks++;
        if (obs !== model_view() || vld !== 0) begin
            n_fail++; $display("FAIL basic_a3: got %h vld %0d exp %h vld 0", obs, vld, model_view());
        end
        press(4'h5, 1'b0, vld);
        n_checks++;
        if (obs !== model_view() || vld !== 1) begin
            n_fail++; $display("FAIL basic_3x5: got %h vld %0d exp %h vld 1", obs, vld, model_view());
        end
        press(4'h7, 1'b0, vld);
        press(4'h3, 1'b0, vld);
        n_checks++;
        if (obs !== model_view() || vld !== 1) begin
            n_fail++; $display("FAIL basic_7x3: got %h vld %0d exp %h vld 1", obs, vld, model_view());
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1 bus.sw_data = 4'($urandom);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== model_view()) begin
            n_fail++; $display("FAIL show_hold: got %h exp %h", obs, model_view());
        end
    endtask

    task automatic test_glitch();
        clear_pulse();
        @(posedge clk); #1 bus.sw_data = 4'hF; bus.btn_load = 1'b1;
        repeat (DEB - 2) @(posedge clk);
        #1 bus.btn_load = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        n_checks++;
        if (obs !== model_view()) begin
            n_fail++; $display("FAIL glitch: got %h exp %h", obs, model_view());
        end
    endtask

    task automatic test_latency();
        clear_pulse();
        @(posedge clk); #1 bus.sw_data = 4'hA; bus.btn_load = 1'b1;
        repeat (DEB + 2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.op_a !== 4'h0) begin
            n_fail++; $display("FAIL latency_early: got %h exp 0", bus.op_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.op_a !== 4'hA || bus.state_dbg !== 2'b01) begin
            n_fail++; $display("FAIL latency_capture: got %h/%b exp a/01", bus.op_a, bus.state_dbg);
        end
        bus.btn_load = 1'b0;
        repeat (DEB + 8) @(negedge clk);
        model_press(4'hA);
    endtask

    task automatic test_clear();
        int vld;
        clear_pulse();
        press(4'h9, 1'b0, vld);
        n_checks++;
        if (obs !== model_view()) begin
            n_fail++; $display("FAIL clear_pre: got %h exp %h", obs, model_view());
        end
        clear_pulse();
        n_checks++;
        if (obs !== 15'd0) begin
            n_fail++; $display("FAIL clear_wait_b: got %h exp 0", obs);
        end
        press(4'h9, 1'b0, vld);
        @(posedge clk); #1 bus.sw_data = 4'h5; bus.btn_load = 1'b1; bus.btn_clear = 1'b1;
        repeat (DEB + 8) @(posedge clk);
        #1 bus.btn_load = 1'b0; bus.btn_clear = 1'b0;
        repeat (DEB + 8) @(negedge clk);
        model_clear();
        n_checks++;
        if (obs !== model_view()) begin
            n_fail++; $display("FAIL clear_vs_load: got %h exp %h", obs, model_view());
        end
    endtask

    task automatic test_show_reload();
        int vld;
        clear_pulse();
        press(4'h3, 1'b0, vld);
        press(4'h5, 1'b0, vld);
        press(4'h2, 1'b0, vld);
        n_checks++;
        if (obs !== model_view() || bus.op_b !== 4'h5 || vld !== 0) begin
            n_fail++; $display("FAIL reload_a2: got %h vld %0d exp %h vld 0", obs, vld, model_view());
        end
        press(4'h4, 1'b0, vld);
        n_checks++;
        if (obs !== model_view() || bus.result_q !== 4'h8 || vld !== 1) begin
            n_fail++; $display("FAIL reload_2x4: got %h vld %0d exp %h vld 1", obs, vld, model_view());
        end
    endtask

    task automatic test_random();
        int vld, exp_vld;
        logic [3:0] sw;
        clear_pulse();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                clear_pulse();
                exp_vld = 0;
                vld = 0;
            end else begin
                exp_vld = (m_phase == 1) ? 1 : 0;
                sw = 4'($urandom);
                press(sw, 1'($urandom), vld);
            end
            n_checks++;
            if (obs !== model_view() || vld !== exp_vld) begin
                n_fail++;
                $display("FAIL random_%0d: got %h vld %0d exp %h vld %0d", i, obs, vld, model_view(), exp_vld);
            end
        end
    endtask

    task automatic test_reset_exec();
        int vld;
        bit seen;
        seen = 1'b0;
        clear_pulse();
        press(4'h6, 1'b0, vld);
        @(posedge clk); #1 bus.sw_data = 4'h9; bus.btn_load = 1'b1;
        for (int i = 0; i < 3 * DEB && !seen; i++) begin
            @(negedge clk);
            if (bus.op_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL exec_reached: got 0 exp 1");
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 15'd0 || bus.op_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_exec: got %h/%b exp 0/0", obs, bus.op_valid);
        end
        bus.btn_load = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        repeat (DEB + 4) @(negedge clk);
        n_checks++;
        if (obs !== model_view()) begin
            n_fail++; $display("FAIL post_reset_idle: got %h exp %h", obs, model_view());
        end
        press(4'h6, 1'b0, vld);
        press(4'h7, 1'b0, vld);
        n_checks++;
        if (obs !== model_view() || vld !== 1) begin
            n_fail++; $display("FAIL post_reset_6x7: got %h vld %0d exp %h vld 1", obs, vld, model_view());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_latency();
        test_clear();
        test_show_reload();
        test_random();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
